// File: rtl/shift_sfr_ctrl.sv
// shift_sfr_ctrl: sequencer for a left/right shift SFR.
// Accepts "load value, shift N positions in one direction", drives the
// SFR's ld/left/right/D pins cycle by cycle, captures Q after the last shift
// and returns it with a one-cycle done pulse.
// Optional feature: define SHIFT_SFR_CTRL_ABORT_EN to add an abort input that
// cancels a command while it is in LOAD or SHIFT.

module shift_sfr_ctrl #(
    parameter int SIZE = 32,
    parameter int AW   = $clog2(SIZE) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dir,
    input  logic [AW-1:0]   amt,
    input  logic [SIZE-1:0] data_in,
`ifdef SHIFT_SFR_CTRL_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] result,
    output logic            sfr_ld,
    output logic            sfr_left,
    output logic            sfr_right,
    output logic [SIZE-1:0] sfr_D,
    input  logic [SIZE-1:0] sfr_Q
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPT,
        DONE
    } state_t;

    localparam logic [AW-1:0] SIZE_AW = AW'(SIZE);
    localparam logic [AW-1:0] ONE_AW  = AW'(1);

    state_t          state;
    state_t          state_nxt;
    logic            dir_q;
    logic [SIZE-1:0] data_q;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   amt_clamped;
    logic            abort_req;

    // Shifting more than SIZE places gives the same all-zero result as SIZE.
    assign amt_clamped = (amt > SIZE_AW) ? SIZE_AW : amt;

`ifdef SHIFT_SFR_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the SFR control pins are pure decodes of the state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        sfr_ld    = 1'b0;
        sfr_left  = 1'b0;
        sfr_right = 1'b0;
        sfr_D     = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sfr_ld    = 1'b1;
                sfr_D     = data_q;
                state_nxt = (cnt != '0) ? SHIFT : CAPT;
                if (abort_req) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                sfr_left  = ~dir_q;
                sfr_right = dir_q;
                if (cnt == ONE_AW) begin
                    state_nxt = CAPT;
                end
                if (abort_req) begin
                    state_nxt = IDLE;
                end
            end
            CAPT: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command registers, shift counter and the captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q  <= 1'b0;
            data_q <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q  <= dir;
                        data_q <= data_in;
                        cnt    <= amt_clamped;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - ONE_AW;
                end
                CAPT: begin
                    result <= sfr_Q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sfr_ctrl.sv
// tb_shift_sfr_ctrl: self-checking bench for shift_sfr_ctrl.
// Contains a behavioural model of the shift SFR driven by the DUT's pins and
// a reference computed directly from shift arithmetic.
// Exercises the abort input when SHIFT_SFR_CTRL_ABORT_EN is defined.

module tb_shift_sfr_ctrl;

    localparam int SIZE = 32;
    localparam int AW   = $clog2(SIZE) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            dir;
    logic [AW-1:0]   amt;
    logic [SIZE-1:0] data_in;
`ifdef SHIFT_SFR_CTRL_ABORT_EN
    logic            abort;
`endif
    logic            busy;
    logic            done;
    logic [SIZE-1:0] result;
    logic            sfr_ld;
    logic            sfr_left;
    logic            sfr_right;
    logic [SIZE-1:0] sfr_D;
    logic [SIZE-1:0] sfr_Q = '0;

    int              checks   = 0;
    int              failures = 0;
    logic [SIZE-1:0] exp_result = '0;

    shift_sfr_ctrl #(.SIZE(SIZE), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .amt       (amt),
        .data_in   (data_in),
`ifdef SHIFT_SFR_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .sfr_ld    (sfr_ld),
        .sfr_left  (sfr_left),
        .sfr_right (sfr_right),
        .sfr_D     (sfr_D),
        .sfr_Q     (sfr_Q)
    );

    always #5 clk = ~clk;

    // Behavioural shift SFR (no reset, like the real register).
    always @(posedge clk) begin
        if (sfr_ld) sfr_Q <= sfr_D;
        else if (sfr_left) sfr_Q <= sfr_Q << 1;
        else if (sfr_right) sfr_Q <= sfr_Q >> 1;
    end

    function automatic int clampAmt(input int a);
        return (a > SIZE) ? SIZE : a;
    endfunction

    function automatic logic [SIZE-1:0] refResult(input logic [SIZE-1:0] d, input int a, input bit dr);
        int s;
        s = clampAmt(a);
        if (s >= SIZE) return '0;
        return dr ? (d >> s) : (d << s);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one command from IDLE; with junk=1 start stays high with other
    // operands for the whole command, including the DONE cycle.
    task automatic applyStimulus(input logic [SIZE-1:0] d, input int a, input bit dr, input bit junk);
        int n, s, ld_cnt, left_cnt, right_cnt, bad_excl, bad_d;
        logic [SIZE-1:0] expv;
        s = clampAmt(a);
        expv = refResult(d, a, dr);
        n = 1; ld_cnt = 0; left_cnt = 0; right_cnt = 0; bad_excl = 0; bad_d = 0;
        checkOutput("idle_busy", busy, 0);
        data_in = d; amt = AW'(a); dir = dr; start = 1'b1;
        @(posedge clk); #1;
        start = junk;
        if (junk) begin
            data_in = ~d; amt = AW'((s == 0) ? 5 : 0); dir = ~dr;
        end
        checkOutput("busy_after_start", busy, 1);
        checkOutput("result_hold", result, exp_result);
        while (n < 200) begin
            if (sfr_ld) begin
                ld_cnt++;
                if (sfr_D !== d) bad_d++;
            end else if (sfr_D !== '0) begin
                bad_d++;
            end
            if (sfr_left) left_cnt++;
            if (sfr_right) right_cnt++;
            if (int'(sfr_ld) + int'(sfr_left) + int'(sfr_right) > 1) bad_excl++;
            if (done === 1'b1) break;
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", n, s + 3);
        checkOutput("result", result, expv);
        checkOutput("ld_cycles", ld_cnt, 1);
        checkOutput("left_cycles", left_cnt, dr ? 0 : s);
        checkOutput("right_cycles", right_cnt, dr ? s : 0);
        checkOutput("ctrl_exclusive", bad_excl, 0);
        checkOutput("sfr_D_value", bad_d, 0);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("back_idle", busy, 0);
        checkOutput("result_kept", result, expv);
        exp_result = expv;
    endtask

    initial begin
        logic [SIZE-1:0] rd;
        int ra;
        int dones;
        bit rdir;

        rst = 1'b1; start = 1'b0; dir = 1'b0; amt = '0; data_in = '0;
`ifdef SHIFT_SFR_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_ctrl", {sfr_ld, sfr_left, sfr_right}, 0);
        checkOutput("rst_sfr_D", sfr_D, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed commands
        applyStimulus(32'h0000_00F0, 4, 1'b0, 1'b0);
        applyStimulus(32'h8000_0000, 8, 1'b1, 1'b0);
        applyStimulus(32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 40, 1'b0, 1'b0);
        applyStimulus(32'h1234_5678, 5, 1'b1, 1'b1);
        applyStimulus(32'hA5A5_0001, 3, 1'b0, 1'b0);
        applyStimulus(32'h8765_4321, 32, 1'b1, 1'b0);

        // Randomized commands
        for (int i = 0; i < 16; i++) begin
            rd = $urandom;
            ra = $urandom_range(0, 40);
            rdir = 1'($urandom_range(0, 1));
            applyStimulus(rd, ra, rdir, 1'b0);
        end

        // Reset in the third SHIFT cycle
        applyStimulus(32'h0000_0001, 1, 1'b0, 1'b0);
        data_in = 32'h0F0F_0F0F; amt = AW'(10); dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ctrl", {sfr_ld, sfr_left, sfr_right}, 0);
        checkOutput("midrst_sfr_D", sfr_D, 0);
        checkOutput("midrst_result", result, 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        checkOutput("midrst_no_done", dones, 0);
        exp_result = '0;
        applyStimulus(32'hC000_0003, 2, 1'b1, 1'b0);

`ifdef SHIFT_SFR_CTRL_ABORT_EN
        // Abort in LOAD (wait 0) and in SHIFT (wait 2)
        for (int w = 0; w <= 2; w += 2) begin
            applyStimulus(32'h0000_0003, 2, 1'b0, 1'b0);
            data_in = 32'hFFFF_0000; amt = AW'(10); dir = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (w) begin
                @(posedge clk); #1;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_ctrl", {sfr_ld, sfr_left, sfr_right}, 0);
            checkOutput("abort_result", result, exp_result);
            dones = 0;
            for (int i = 0; i < 20; i++) begin
                if (done) dones++;
                @(posedge clk); #1;
            end
            checkOutput("abort_no_done", dones, 0);
        end
        applyStimulus(32'h0000_0100, 4, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
